// File: rtl/ahb_slv_pkg.sv
// ============================================================================
// Module      : ahb_slv_pkg
// Description : Shared AHB encodings and slave FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_slv_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

endpackage

`default_nettype wire

// File: rtl/ahb_sram_bytelane.sv
// ============================================================================
// Module      : ahb_sram_bytelane
// Description : Decodes transfer size and low address bits into byte-lane
//               enables and flags oversize or misaligned transfers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_sram_bytelane #(
    parameter int DATA_WIDTH = 32,
    parameter int LO_W       = 2
) (
    input  logic [2:0]              i_size,
    input  logic [LO_W-1:0]         i_addr_lo,
    output logic [DATA_WIDTH/8-1:0] o_lanes,
    output logic                    o_illegal
);

    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANES);

    int w_nbytes;
    int w_lo;

    always_comb begin
        w_nbytes  = 1 << i_size;
        w_lo      = int'(i_addr_lo);
        o_illegal = (int'(i_size) > LANE_BITS) || ((w_lo & (w_nbytes - 1)) != 0);
        o_lanes   = '0;
        for (int i = 0; i < LANES; i++) begin
            o_lanes[i] = (i >= w_lo) && (i < w_lo + w_nbytes);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB slave with a word-organised flop-array memory, optional
//               wait states (AHB_SLV_WAIT_EN) and two-cycle ERROR responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_sram_slave
    import ahb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH  = `AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = `AHB_DATA_WIDTH,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            trans,
    input  logic                  write,
    input  logic [2:0]            size,
    input  logic [2:0]            burst,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  resp
);

    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int LO_W      = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int IDX_W     = $clog2(MEM_DEPTH);

    slv_state_e              r_state;
    logic                    r_ready;
    logic                    r_resp;
    logic                    r_pend;
    logic                    r_write;
    logic [IDX_W-1:0]        r_idx;
    logic [LANES-1:0]        r_lanes;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic [LO_W-1:0]         w_addr_lo;
    logic [IDX_W-1:0]        w_idx;
    logic [LANES-1:0]        w_lanes;
    logic                    w_illegal;
    logic                    w_accept;
    logic                    w_mem_we;
    logic                    w_unused;

`ifdef AHB_SLV_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] C_WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    logic [CNT_W-1:0]        r_cnt;
`endif

    generate
        if (LANE_BITS > 0) begin : g_lo
            assign w_addr_lo = addr[LANE_BITS-1:0];
        end else begin : g_lo_none
            assign w_addr_lo = '0;
        end
    endgenerate

    // Upper address bits belong to the decoder and are deliberately dropped.
    assign w_idx    = addr[LANE_BITS +: IDX_W];
    assign w_unused = ^{burst, addr, trans[0], (WAIT_CYCLES != 0)};

    ahb_sram_bytelane #(
        .DATA_WIDTH (DATA_WIDTH),
        .LO_W       (LO_W)
    ) u_bytelane (
        .i_size     (size),
        .i_addr_lo  (w_addr_lo),
        .o_lanes    (w_lanes),
        .o_illegal  (w_illegal)
    );

    assign w_accept = sel & ready_in
                    & ((trans == TRANS_NONSEQ) | (trans == TRANS_SEQ))
                    & ((r_state == ST_IDLE) | (r_state == ST_ERR2));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_resp  <= RESP_OKAY;
            r_pend  <= 1'b0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_lanes <= '0;
`ifdef AHB_SLV_WAIT_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    if (w_accept) begin
                        r_write <= write;
                        r_idx   <= w_idx;
                        r_lanes <= w_lanes;
                        if (w_illegal) begin
                            r_state <= ST_ERR1;
                            r_ready <= 1'b0;
                            r_resp  <= RESP_ERROR;
                            r_pend  <= 1'b0;
                        end else begin
                            r_pend  <= 1'b1;
                            r_resp  <= RESP_OKAY;
`ifdef AHB_SLV_WAIT_EN
                            if (WAIT_CYCLES > 0) begin
                                r_state <= ST_WAIT;
                                r_ready <= 1'b0;
                                r_cnt   <= C_WAIT_LOAD;
                            end else begin
                                r_state <= ST_IDLE;
                                r_ready <= 1'b1;
                            end
`else
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
`endif
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_resp  <= RESP_OKAY;
                        r_pend  <= 1'b0;
                    end
                end
                ST_WAIT: begin
`ifdef AHB_SLV_WAIT_EN
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
`else
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
`endif
                end
                ST_ERR1: begin
                    r_state <= ST_ERR2;
                    r_ready <= 1'b1;
                    r_resp  <= RESP_ERROR;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_resp  <= RESP_OKAY;
                    r_pend  <= 1'b0;
                end
            endcase
        end
    end

    // r_pend is cleared asynchronously by reset, so an aborted write never lands.
    assign w_mem_we = r_pend & r_write & r_ready;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (r_lanes[i]) begin
                    r_mem[r_idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = (r_pend & ~r_write & r_ready) ? r_mem[r_idx] : '0;
    assign ready = r_ready;
    assign resp  = r_resp;

endmodule

`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Directed scoreboard bench for ahb_sram_slave; follows the
//               AHB_SLV_WAIT_EN build setting for expected wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_sram_slave;
    import ahb_slv_pkg::*;

`ifdef AHB_SLV_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
    logic        ready_in;
    logic [31:0] rdata;
    logic        ready;
    logic        resp;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    always #5 clk = ~clk;

    // Single slave on the bus, so the multiplexer's ready is our own.
    assign ready_in = ready;

    ahb_sram_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (256),
        .WAIT_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sel      (sel),
        .addr     (addr),
        .trans    (trans),
        .write    (write),
        .size     (size),
        .burst    (burst),
        .wdata    (wdata),
        .ready_in (ready_in),
        .rdata    (rdata),
        .ready    (ready),
        .resp     (resp)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Monitor: tracks data phases from the address-phase handshake and pops
    // one expectation per completed transfer.
    initial begin : monitor
        bit   active;
        int   k;
        exp_t e;
        active = 1'b0;
        k      = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || !rstn) begin
                active = 1'b0;
                continue;
            end
            if (active) begin
                k++;
                if (q.size() == 0) begin
                    check("queue_empty", 32'd1, 32'd0);
                    active = 1'b0;
                end else begin
                    e = q[0];
                    check("dp_ready", {31'd0, ready}, {31'd0, (e.err ? (k >= 2) : (k > W))});
                    check("dp_resp", {31'd0, resp}, {31'd0, e.err});
                    if (ready) begin
                        check(e.rd ? "read_data" : "nonread_rdata", rdata, e.rd ? e.data : 32'd0);
                        void'(q.pop_front());
                        active = 1'b0;
                    end else begin
                        check("wait_rdata", rdata, 32'd0);
                        if (k > W + 3) begin
                            check("dp_timeout", k, 32'd0);
                            void'(q.pop_front());
                            active = 1'b0;
                        end
                    end
                end
            end else begin
                check("idle_ready", {31'd0, ready}, 32'd1);
                check("idle_resp", {31'd0, resp}, 32'd0);
                check("idle_rdata", rdata, 32'd0);
            end
            if (sel && ready && trans[1]) begin
                active = 1'b1;
                k      = 0;
            end
        end
    end

    task automatic xfer(bit wr, logic [31:0] a, logic [2:0] sz, logic [1:0] tr,
                        logic [31:0] wd, bit err, logic [31:0] rexp);
        exp_t e;
        int   n;
        e.err  = err;
        e.rd   = !wr && !err;
        e.data = rexp;
        q.push_back(e);
        sel   = 1'b1;
        addr  = a;
        write = wr;
        size  = sz;
        trans = tr;
        burst = (tr == TRANS_SEQ) ? 3'b011 : 3'b000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 30);
        if (!ready) check("accept_timeout", n, 32'd0);
        @(posedge clk);
        #1;
        wdata = wd;
        sel   = 1'b0;
        trans = TRANS_IDLE;
    endtask

    task automatic idle_cyc(int n);
        sel   = 1'b0;
        trans = TRANS_IDLE;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue", q.size(), 32'd0);
    endtask

    initial begin : stim
        rstn  = 1'b0;
        sel   = 1'b0;
        addr  = '0;
        trans = TRANS_IDLE;
        write = 1'b0;
        size  = 3'd0;
        burst = 3'd0;
        wdata = '0;
        #12;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_resp", {31'd0, resp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        mon_en = 1'b1;
        idle_cyc(2);

        // Word write then immediate read of the same word.
        xfer(1, 32'h10, 3'd2, TRANS_NONSEQ, 32'hDEADBEEF, 0, 0);
        xfer(0, 32'h10, 3'd2, TRANS_NONSEQ, 32'h0, 0, 32'hDEADBEEF);
        // Byte write into lane 3 over a stored word.
        xfer(1, 32'h20, 3'd2, TRANS_NONSEQ, 32'h11223344, 0, 0);
        xfer(1, 32'h23, 3'd0, TRANS_NONSEQ, 32'hAAAAAAAA, 0, 0);
        xfer(0, 32'h20, 3'd2, TRANS_NONSEQ, 32'h0, 0, 32'hAA223344);
        // Misaligned halfword and oversize transfer both error, memory intact.
        xfer(1, 32'h21, 3'd1, TRANS_NONSEQ, 32'hFFFFFFFF, 1, 0);
        xfer(1, 32'h20, 3'd3, TRANS_NONSEQ, 32'hFFFFFFFF, 1, 0);
        xfer(0, 32'h20, 3'd2, TRANS_NONSEQ, 32'h0, 0, 32'hAA223344);
        // Legal halfword and byte writes.
        xfer(1, 32'h22, 3'd1, TRANS_NONSEQ, 32'h55660000, 0, 0);
        xfer(0, 32'h20, 3'd2, TRANS_NONSEQ, 32'h0, 0, 32'h55663344);
        xfer(1, 32'h21, 3'd0, TRANS_NONSEQ, 32'h0000BB00, 0, 0);
        xfer(0, 32'h20, 3'd2, TRANS_NONSEQ, 32'h0, 0, 32'h5566BB44);
        // Upper address bits are ignored.
        xfer(0, 32'h410, 3'd2, TRANS_NONSEQ, 32'h0, 0, 32'hDEADBEEF);
        idle_cyc(1);

        // Four-beat burst write, a BUSY cycle, then a burst read back.
        xfer(1, 32'h0, 3'd2, TRANS_NONSEQ, 32'h0A0B0C0D, 0, 0);
        xfer(1, 32'h4, 3'd2, TRANS_SEQ,    32'h11111111, 0, 0);
        xfer(1, 32'h8, 3'd2, TRANS_SEQ,    32'h22222222, 0, 0);
        xfer(1, 32'hC, 3'd2, TRANS_SEQ,    32'h33333333, 0, 0);
        sel   = 1'b1;
        trans = TRANS_BUSY;
        @(posedge clk);
        #1;
        xfer(0, 32'h0, 3'd2, TRANS_NONSEQ, 32'h0, 0, 32'h0A0B0C0D);
        xfer(0, 32'h4, 3'd2, TRANS_SEQ,    32'h0, 0, 32'h11111111);
        xfer(0, 32'h8, 3'd2, TRANS_SEQ,    32'h0, 0, 32'h22222222);
        xfer(0, 32'hC, 3'd2, TRANS_SEQ,    32'h0, 0, 32'h33333333);
        idle_cyc(1);
        drain();

        // Reset in the middle of a write's data phase aborts the write.
        mon_en = 1'b0;
        sel    = 1'b1;
        addr   = 32'h10;
        write  = 1'b1;
        size   = 3'd2;
        trans  = TRANS_NONSEQ;
        @(posedge clk);
        #1;
        sel   = 1'b0;
        trans = TRANS_IDLE;
        wdata = 32'h99999999;
`ifdef AHB_SLV_WAIT_EN
        check("wait_ready_low", {31'd0, ready}, 32'd0);
`endif
        #2;
        rstn = 1'b0;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_resp", {31'd0, resp}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        q.delete();
        mon_en = 1'b1;
        idle_cyc(1);
        xfer(0, 32'h10, 3'd2, TRANS_NONSEQ, 32'h0, 0, 32'hDEADBEEF);
        idle_cyc(2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
